lif_scheduler: RTL

Time-multiplexed controller that shares one leaky-integrate-and-fire update datapath among `N_NEURONS` neurons. It holds per-neuron membrane state, input current and threshold, and sweeps all neurons once per `start` pulse (one timestep). Spikes are emitted as neuron IDs over a valid/ready port and collected in a per-timestep spike vector. It sits between the stimulus/config interface and downstream spike routing.

---
 rtl/lif_pkg.sv | 16 +
 rtl/lif_update_unit.sv | 36 +++
 rtl/lif_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared definitions for the leaky-integrate-and-fire scheduler: FSM encoding
// and the default leak / threshold constants.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lif_state_e;

  // Leak term is (state * LEAK_NUM) >> LEAK_SHIFT, so LEAK_NUM must stay below 2^LEAK_SHIFT.
  localparam int LEAK_NUM_DEF   = 112;
  localparam int LEAK_SHIFT     = 7;
  localparam int THRESH_RST_DEF = 200;

endpackage

// File: rtl/lif_update_unit.sv
// Combinational LIF neuron update: threshold compare, leak, saturating integrate.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int W        = 8,
  parameter int LEAK_NUM = LEAK_NUM_DEF
) (
  input  logic [W-1:0] state,
  input  logic [W-1:0] current,
  input  logic [W-1:0] threshold,
  output logic [W-1:0] next_state,
  output logic         spike
);

  localparam logic [LEAK_SHIFT-1:0] LEAK_K = LEAK_SHIFT'(LEAK_NUM);

  logic [W+LEAK_SHIFT-1:0] product_s;
  logic [W-1:0]            leak_s;
  logic [W:0]              sum_s;

  // Fire on reaching threshold, otherwise leak the old state and add current, clamping at all-ones.
  always_comb begin
    product_s = {{LEAK_SHIFT{1'b0}}, state} * {{W{1'b0}}, LEAK_K};
    leak_s    = product_s[W+LEAK_SHIFT-1:LEAK_SHIFT];
    sum_s     = {1'b0, current} + {1'b0, leak_s};
    spike     = (state >= threshold);
    if (spike) begin
      next_state = '0;
    end else if (sum_s[W]) begin
      next_state = '1;
    end else begin
      next_state = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF controller: sweeps all neurons through one shared update
// unit per start pulse and reports spikes over a valid/ready port.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter  int N_NEURONS  = 8,
  parameter  int W          = 8,
  parameter  int THRESH_RST = THRESH_RST_DEF,
  parameter  int LEAK_NUM   = LEAK_NUM_DEF,
  localparam int AW         = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cur_we,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        wr_addr,
  input  logic [W-1:0]         wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 spike_valid,
  output logic [AW-1:0]        spike_id,
  input  logic                 spike_ready,
  output logic [N_NEURONS-1:0] spike_vec,
  input  logic [AW-1:0]        probe_addr,
  output logic [W-1:0]         probe_state
);

  localparam logic [W-1:0]  THR_INIT = W'(THRESH_RST);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

  lif_state_e           fsm_r;
  logic [AW-1:0]        idx_r;
  logic                 busy_r;
  logic                 done_r;
  logic [N_NEURONS-1:0] spike_vec_r;
  logic                 spike_valid_r;
  logic [AW-1:0]        spike_id_r;
  logic [W-1:0]         mem_state_r [N_NEURONS];
  logic [W-1:0]         cur_r       [N_NEURONS];
  logic [W-1:0]         thr_r       [N_NEURONS];

  logic [W-1:0] upd_next_s;
  logic         upd_spike_s;
  logic         stall_s;
  logic         advance_s;
  logic         load_s;

  lif_update_unit #(
    .W        (W),
    .LEAK_NUM (LEAK_NUM)
  ) u_update (
    .state      (mem_state_r[idx_r]),
    .current    (cur_r[idx_r]),
    .threshold  (thr_r[idx_r]),
    .next_state (upd_next_s),
    .spike      (upd_spike_s)
  );

  // A spiking neuron may only commit when the spike register is free or being drained.
  always_comb begin
    stall_s = upd_spike_s && spike_valid_r && !spike_ready;
    if (fsm_r == ST_RUN) begin
      advance_s = !stall_s;
    end else begin
      advance_s = 1'b0;
    end
    load_s = advance_s && upd_spike_s;
  end

  // Timestep FSM with index counter, status flags and the per-step spike vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r       <= ST_IDLE;
      idx_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      spike_vec_r <= '0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            fsm_r       <= ST_RUN;
            busy_r      <= 1'b1;
            idx_r       <= '0;
            spike_vec_r <= '0;
          end
        end
        ST_RUN: begin
          done_r <= 1'b0;
          if (advance_s) begin
            spike_vec_r[idx_r] <= spike_vec_r[idx_r] | upd_spike_s;
            if (idx_r == LAST_IDX) begin
              fsm_r  <= ST_DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              idx_r <= idx_r + AW'(1);
            end
          end
        end
        ST_DONE: begin
          fsm_r  <= ST_IDLE;
          done_r <= 1'b0;
        end
        default: begin
          fsm_r  <= ST_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Spike output register; a new load takes priority over the drain so back-to-back IDs have no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_valid_r <= 1'b0;
      spike_id_r    <= '0;
    end else if (load_s) begin
      spike_valid_r <= 1'b1;
      spike_id_r    <= idx_r;
    end else if (spike_valid_r && spike_ready) begin
      spike_valid_r <= 1'b0;
    end
  end

  // Membrane state array, written only by the sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_state_r[i] <= '0;
      end
    end else if (advance_s) begin
      mem_state_r[idx_r] <= upd_next_s;
    end
  end

  // Current and threshold arrays; host writes are accepted in every FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        cur_r[i] <= '0;
        thr_r[i] <= THR_INIT;
      end
    end else begin
      if (cur_we) begin
        cur_r[wr_addr] <= wr_data;
      end
      if (cfg_we) begin
        thr_r[wr_addr] <= wr_data;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign spike_valid = spike_valid_r;
  assign spike_id    = spike_id_r;
  assign spike_vec   = spike_vec_r;
  assign probe_state = mem_state_r[probe_addr];

endmodule
